alu_mc: RTL

- Parametrised multi-cycle ALU; next generation of the single-cycle 32-bit ALU used in the MIPS-lite datapath.
- Executes every existing ALU-control operation in 1 cycle. Adds iterative unsigned multiply and divide that take WIDTH cycles.
- Uses a start/busy/done handshake so the controller can stall the datapath.
- Sits between the register-file read ports and the ALU-result/HI-LO writeback path.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mc_iter.sv | 78 +++++++
 rtl/alu_mc.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: ALU-control codes and FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

   // ALU-control codes carried on gin
   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SLT   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_MULTU = 4'b0011;
   localparam logic [3:0] OP_OR    = 4'b0100;
   localparam logic [3:0] OP_DIVU  = 4'b0101;
   localparam logic [3:0] OP_SLTU  = 4'b0111;
   localparam logic [3:0] OP_AND   = 4'b1000;
   localparam logic [3:0] OP_NOR   = 4'b1001;
   localparam logic [3:0] OP_BNE   = 4'b1010;
   localparam logic [3:0] OP_BGEZ  = 4'b1011;
   localparam logic [3:0] OP_BGTZ  = 4'b1100;
   localparam logic [3:0] OP_BLEZ  = 4'b1101;
   localparam logic [3:0] OP_BLTZ  = 4'b1110;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ITER = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/alu_mc_iter.sv
// Shared shift/accumulate engine for MULTU (shift-add) and DIVU (restoring).
// Latency: one iteration per clock while step=1; WIDTH steps give the result.
// Backpressure: none; the owner only asserts load when idle and step while iterating.
//
// Ports: clk, reset (sync, active-high); load latches a/b/div and arms the counter;
// step advances one iteration; acc_nxt/sr_nxt are the post-step values (HI/remainder
// and LO/quotient), so the owner can capture the final result on the last step.
module alu_mc_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] acc_nxt,
   output logic [WIDTH-1:0] sr_nxt,
   output logic             last
);

   logic [WIDTH-1:0] acc;    // product high half / partial remainder
   logic [WIDTH-1:0] sr;     // multiplier bits -> product low half / dividend -> quotient
   logic [WIDTH-1:0] opb;    // multiplicand or divisor
   logic             mode_div;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH:0]   add_w;  // carry bit is kept so the shift-right does not lose it
   logic [WIDTH:0]   shl_w;  // remainder shifted left with next dividend bit
   logic [WIDTH-1:0] diff_w;

   assign last = (cnt == CNT_W'(1));

   always_comb begin
      add_w  = {1'b0, acc} + (sr[0] ? {1'b0, opb} : '0);
      shl_w  = {acc, sr[WIDTH-1]};
      // Only consumed when shl_w >= opb, so the result fits in WIDTH bits.
      diff_w = shl_w[WIDTH-1:0] - opb;
      acc_nxt = add_w[WIDTH:1];
      sr_nxt  = {add_w[0], sr[WIDTH-1:1]};
      if (mode_div) begin
         if (shl_w >= {1'b0, opb}) begin
            acc_nxt = diff_w;
            sr_nxt  = {sr[WIDTH-2:0], 1'b1};
         end else begin
            acc_nxt = shl_w[WIDTH-1:0];
            sr_nxt  = {sr[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         sr       <= '0;
         opb      <= '0;
         mode_div <= 1'b0;
         cnt      <= '0;
      end else if (load) begin
         acc      <= '0;
         sr       <= a;
         opb      <= b;
         mode_div <= div;
         cnt      <= CNT_W'(WIDTH);
      end else if (step) begin
         acc <= acc_nxt;
         sr  <= sr_nxt;
         // saturate at zero rather than wrap
         if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle MIPS-lite ALU: single-cycle ALU ops plus iterative MULTU/DIVU.
// Latency: 1 cycle for single-cycle ops, undefined gin and DIVU by zero; WIDTH+1 for MULTU/DIVU.
// Backpressure: start is accepted only in IDLE; starts while busy or during done are dropped.
//
// Ports: clk, reset (sync, active-high); start/gin/a/b request; sum (LO/quotient),
// hi (HI/remainder, else 0), zout (sum==0), busy, done (1-cycle pulse), err.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       gin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] hi,
   output logic             zout,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           state;

   logic [WIDTH-1:0] sc_sum;
   logic [WIDTH-1:0] sc_hi;
   logic             sc_err;
   logic             iter_op;
   logic             a_neg;
   logic             a_zero;

   logic [WIDTH-1:0] it_hi;
   logic [WIDTH-1:0] it_lo;
   logic             it_last;
   logic             it_load;
   logic             it_step;

   assign a_neg  = a[WIDTH-1];
   assign a_zero = (a == '0);

   // Single-cycle result; branch ops return 0 when the condition holds so zout=taken.
   always_comb begin
      sc_sum  = '0;
      sc_hi   = '0;
      sc_err  = 1'b0;
      iter_op = 1'b0;
      case (gin)
         OP_ADD:   sc_sum = a + b;
         OP_SUB:   sc_sum = a - b;
         OP_SLT:   sc_sum[0] = ($signed(a) < $signed(b));
         OP_SLTU:  sc_sum[0] = (a < b);
         OP_AND:   sc_sum = a & b;
         OP_OR:    sc_sum = a | b;
         OP_NOR:   sc_sum = ~(a | b);
         OP_BNE:   sc_sum[0] = (a == b);
         OP_BGEZ:  sc_sum[0] = a_neg;
         OP_BGTZ:  sc_sum[0] = a_neg | a_zero;
         OP_BLEZ:  sc_sum[0] = ~(a_neg | a_zero);
         OP_BLTZ:  sc_sum[0] = ~a_neg;
         OP_MULTU: iter_op = 1'b1;
         OP_DIVU: begin
            // divide by zero short-circuits with the conventional all-ones quotient
            if (b == '0) begin
               sc_sum = '1;
               sc_hi  = a;
               sc_err = 1'b1;
            end else begin
               iter_op = 1'b1;
            end
         end
         default:  sc_err = 1'b1;
      endcase
   end

   assign it_load = (state == IDLE) && start && iter_op;
   assign it_step = (state == ITER);

   alu_mc_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk     (clk),
      .reset   (reset),
      .load    (it_load),
      .step    (it_step),
      .div     (gin == OP_DIVU),
      .a       (a),
      .b       (b),
      .acc_nxt (it_hi),
      .sr_nxt  (it_lo),
      .last    (it_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sum   <= '0;
         hi    <= '0;
         zout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (iter_op) begin
                     state <= ITER;
                     busy  <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     sum   <= sc_sum;
                     hi    <= sc_hi;
                     zout  <= (sc_sum == '0);
                     err   <= sc_err;
                  end
               end
            end
            ITER: begin
               // capture the post-step values of the final iteration directly
               if (it_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  sum   <= it_lo;
                  hi    <= it_hi;
                  zout  <= (it_lo == '0);
                  err   <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
